// File: rtl/m_multibyte_add_ctrl.sv
// m_multibyte_add_ctrl
//   Performs an NBYTES-wide add by stepping one 8-bit ripple adder (a chain of
//   mFullAdder cells) over the operand bytes, LSB first, carrying between steps.
//   Start/done handshake toward the ALU control; all outputs are registered.
//
//   Optional feature macro: SUBTRACT_EN. When defined, the iSub port exists and
//   iSub=1 computes A-B (B inverted, byte-0 carry-in forced to 1, iC ignored).
//
// Ports
//   iClk, iRst       clock, asynchronous active-high reset
//   iStart           request pulse, sampled only in IDLE
//   iA, iB, iC       operands and carry-in, latched on the accepting edge
//   iSub             subtract select (SUBTRACT_EN only)
//   oSum             result register, byte k written on RUN step k
//   oCarry           carry-out of the most significant byte
//   oOverflow        two's-complement overflow of the full-width result
//   oBusy            high in RUN and DONE
//   oDone            one-cycle completion pulse

module mFullAdder (
  input  logic iA,
  input  logic iB,
  input  logic iC,
  output logic oS,
  output logic oC
);
  assign oS = iA ^ iB ^ iC;
  assign oC = (iA & iB) | (iC & (iA ^ iB));
endmodule

module m_multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [8*NBYTES-1:0] iA,
  input  logic [8*NBYTES-1:0] iB,
  input  logic                iC,
`ifdef SUBTRACT_EN
  input  logic                iSub,
`endif
  output logic [8*NBYTES-1:0] oSum,
  output logic                oCarry,
  output logic                oOverflow,
  output logic                oBusy,
  output logic                oDone
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;
  logic          sub_eff;

`ifdef SUBTRACT_EN
  logic sub_q, sub_d;
  assign sub_eff = sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  // Byte k of each operand, selected by the step counter.
  logic [7:0] a_byte, b_byte, b_eff, s_byte;
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int j = 0; j < NBYTES; j++) begin
      if (k_q == KW'(j)) begin
        a_byte = a_q[8*j +: 8];
        b_byte = b_q[8*j +: 8];
      end
    end
  end
  assign b_eff = sub_eff ? ~b_byte : b_byte;

  // The single shared 8-bit ripple adder.
  logic [8:0] c;
  assign c[0] = cy_q;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    mFullAdder u_fa (
      .iA(a_byte[i]), .iB(b_eff[i]), .iC(c[i]),
      .oS(s_byte[i]), .oC(c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
`ifdef SUBTRACT_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          a_d     = iA;
          b_d     = iB;
          k_d     = '0;
`ifdef SUBTRACT_EN
          sub_d   = iSub;
          cy_d    = iSub ? 1'b1 : iC;
`else
          cy_d    = iC;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int j = 0; j < NBYTES; j++) begin
          if (k_q == KW'(j)) sum_d[8*j +: 8] = s_byte;
        end
        cy_d = c[8];
        if (k_q == KW'(NBYTES-1)) begin
          // Final byte: its sign bits decide overflow. k is parked at 0
          // rather than incremented so it never wraps.
          carry_d = c[8];
          ovf_d   = (a_byte[7] == b_eff[7]) && (s_byte[7] != a_byte[7]);
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
`ifdef SUBTRACT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign oSum      = sum_q;
  assign oCarry    = carry_q;
  assign oOverflow = ovf_q;
  assign oBusy     = (state_q == S_RUN) || (state_q == S_DONE);
  assign oDone     = (state_q == S_DONE);
endmodule

// File: tb/tb_m_multibyte_add_ctrl.sv
// Self-checking bench for m_multibyte_add_ctrl (NBYTES=4). Reference results
// come from plain wide arithmetic on the whole operands.
module tb_m_multibyte_add_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         iClk = 1'b0;
  logic         iRst, iStart, iC;
  logic [W-1:0] iA, iB;
`ifdef SUBTRACT_EN
  logic         iSub;
`endif
  logic [W-1:0] oSum;
  logic         oCarry, oOverflow, oBusy, oDone;

  m_multibyte_add_ctrl #(.NBYTES(NB)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iA(iA), .iB(iB), .iC(iC),
`ifdef SUBTRACT_EN
    .iSub(iSub),
`endif
    .oSum(oSum), .oCarry(oCarry), .oOverflow(oOverflow),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_sum = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation through the handshake, checked against wide math.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub, input string tag);
    logic [W:0]   full;
    logic [W-1:0] beff;
    logic         cin, exp_ov;
    int           lat;
    beff   = sub ? ~b : b;
    cin    = sub ? 1'b1 : c;
    full   = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, cin};
    exp_ov = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    @(negedge iClk);
    iA = a; iB = b; iC = c; iStart = 1'b1;
`ifdef SUBTRACT_EN
    iSub = sub;
`endif
    @(posedge iClk); #1;                       // E0: accepted
    chk({tag, "_busy"}, 64'(oBusy), 64'd1);
    @(negedge iClk);
    iStart = 1'b0; iA = $urandom; iB = $urandom; iC = 1'($urandom);
`ifdef SUBTRACT_EN
    iSub = 1'($urandom);
`endif
    @(posedge iClk); #1;                       // E1: byte 0 written only
    chk({tag, "_b0"}, 64'(oSum[7:0]), 64'(full[7:0]));
    chk({tag, "_hold"}, 64'(oSum[W-1:8]), 64'(last_sum[W-1:8]));
    // oDone appears in the cycle after E(NB): first seen at E(NB)+#1.
    lat = -1;
    for (int e = 2; e <= NB + 4; e++) begin
      @(posedge iClk); #1;
      if (oDone) begin lat = e; break; end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(NB));
    chk({tag, "_sum"}, 64'(oSum), 64'(full[W-1:0]));
    chk({tag, "_cy"}, 64'(oCarry), 64'(full[W]));
    chk({tag, "_ov"}, 64'(oOverflow), 64'(exp_ov));
    @(posedge iClk); #1;
    chk({tag, "_done1"}, 64'({oDone, oBusy}), 64'd0);
    chk({tag, "_keep"}, 64'(oSum), 64'(full[W-1:0]));
    last_sum = full[W-1:0];
  endtask

  initial begin
    int acc[$];
    int ndone, prev_busy, cnt;
    logic [W:0] full;
    iRst = 1'b1; iStart = 1'b0; iA = '0; iB = '0; iC = 1'b0;
`ifdef SUBTRACT_EN
    iSub = 1'b0;
`endif
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_out", 64'({oSum, oCarry, oOverflow, oBusy, oDone}), 64'd0);
    @(negedge iClk); iRst = 1'b0;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "ff_p1");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "cin");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "negovf");
    for (int i = 0; i < 25; i++)
      run_op($urandom, $urandom, 1'($urandom), 1'b0, "rnd");
`ifdef SUBTRACT_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, "sub57");
    run_op(32'd7, 32'd5, 1'b1, 1'b1, "sub75");
    for (int i = 0; i < 10; i++)
      run_op($urandom, $urandom, 1'($urandom), 1'b1, "rsub");
`endif

    // iStart held: accepts at E0, E6, E12 across 18 edges, one oDone each.
    @(negedge iClk);
    iA = 32'h1234_5678; iB = 32'h0FED_CBA9; iC = 1'b1; iStart = 1'b1;
    ndone = 0; prev_busy = 0;
    for (int e = 0; e < 18; e++) begin
      @(posedge iClk); #1;
      if (oBusy && prev_busy == 0) acc.push_back(e);
      if (oDone) ndone++;
      prev_busy = oBusy;
    end
    @(negedge iClk); iStart = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge iClk); #1;
      if (oDone) ndone++;
    end
    chk("hold_nacc", 64'(acc.size()), 64'd3);
    if (acc.size() == 3) begin
      chk("hold_acc0", 64'(acc[0]), 64'd0);
      chk("hold_acc1", 64'(acc[1]), 64'd6);
      chk("hold_acc2", 64'(acc[2]), 64'd12);
    end
    chk("hold_ndone", 64'(ndone), 64'd3);
    full = {1'b0, 32'h1234_5678} + {1'b0, 32'h0FED_CBA9} + 33'd1;
    chk("hold_sum", 64'(oSum), 64'(full[W-1:0]));
    last_sum = full[W-1:0];

    // Asynchronous reset two edges into RUN aborts without oDone.
    @(negedge iClk);
    iA = 32'hDEAD_BEEF; iB = 32'h1111_1111; iC = 1'b0; iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk); iStart = 1'b0;
    repeat (2) @(posedge iClk);
    #2 iRst = 1'b1;
    #1;
    chk("arst_out", 64'({oSum, oCarry, oOverflow, oBusy, oDone}), 64'd0);
    cnt = 0;
    repeat (2) begin @(posedge iClk); #1; if (oDone) cnt++; end
    @(negedge iClk); iRst = 1'b0;
    repeat (8) begin @(posedge iClk); #1; if (oDone) cnt++; end
    chk("arst_nodone", 64'(cnt), 64'd0);
    last_sum = '0;
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
